hc_dec_pipe: RTL
================

# hc_dec_pipe

Pipelined, flow-controlled Hamming (7,4) decoder that sits directly downstream of the Hamming encoder and any channel/error-injection logic between them. It accepts one 7-bit codeword per cycle, computes the syndrome, corrects any single-bit error, and delivers the 4-bit data word with error status. A running saturating count of corrected words is kept for the bench and for debug.

## Interface
- DATA_WD, 4, data bits per word; only 4 supported.
- CHK_WD, 3, check bits per word; only 3 supported.
- CNT_WD, 16, width of the corrected-error counter.

- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  upstream codeword valid.
- o_ready  output  1  decoder can accept a codeword this cycle.
- i_enc_data  input  DATA_WD+CHK_WD  codeword; bit k is Hamming position k+1.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the output word.
- o_data  output  DATA_WD  corrected data {d3,d2,d1,d0}.
- o_err  output  1  output word had a non-zero syndrome and was corrected.
- o_syndrome  output  CHK_WD  syndrome of the output word (= erroneous position, 0 if clean).
- o_err_cnt  output  CNT_WD  number of corrected words delivered, saturating.
- i_cnt_clr  input  1  synchronous clear of o_err_cnt.

## Operation
- Codeword layout: parity p1,p2,p4 at bits 0,1,3; data d0,d1,d2,d3 at bits 2,4,5,6.
- Syndrome: s0 = b0^b2^b4^b6; s1 = b1^b2^b5^b6; s2 = b3^b4^b5^b6; S = {s2,s1,s0}.
- Correction: if S != 0, invert bit S-1 of the codeword; then extract d0..d3. Errors on parity bits give S in {1,2,4}; data unaffected but o_err still asserts.
- Double-bit errors are not detected; they are mis-corrected as single errors (inherent to (7,4)).
- Stage 1 (S1): registers codeword and syndrome on input handshake (i_valid && o_ready).
- Stage 2 (S2): registers corrected data, o_err, o_syndrome when S1 advances.
- Flow control: s2_free = !s2_valid || i_ready; o_ready = !s1_valid || s2_free. S1 moves to S2 when s1_valid && s2_free. No combinational path from i_valid to o_ready.
- Output holds stable (o_data, o_err, o_syndrome) while o_valid && !i_ready.
- Counter: increments by 1 on each output handshake (o_valid && i_ready) with o_err=1; saturates at all-ones; i_cnt_clr has priority over increment (clear wins in the same cycle).

## Timing
- Reset (i_rst=1 at an edge): s1_valid, s2_valid, o_valid=0, o_data=0, o_err=0, o_syndrome=0, o_err_cnt=0; o_ready=1 in the cycle after reset. Reset mid-stream drops both in-flight words.
- Latency: codeword accepted at edge N appears on o_valid/o_data after edge N+1 (visible in cycle N+1 → N+2 window), i.e. 2 register stages.
- Throughput: 1 word/cycle with i_ready held high.
- Backpressure: with i_ready low, at most 2 words buffered; o_ready deasserts the cycle after S1 and S2 both hold valid words. When i_ready returns, S2 drains and S1 advances in the same edge, and o_ready rises combinationally in that cycle.
- Simultaneous input accept and output drain in one cycle: both occur, no bubble.

## Test plan
- Clean stream: send codewords of data 0x0..0xF back-to-back, i_ready=1 → same data out 2 cycles later, one per cycle, o_err=0, o_syndrome=0, o_err_cnt=0.
- Single-bit sweep: data 0xB, flip each bit 0..6 in turn → o_data=0xB every time, o_err=1, o_syndrome=1..7 respectively, o_err_cnt=7.
- Backpressure: stream 6 words, hold i_ready=0 for 5 cycles mid-stream → o_ready low after 2 buffered, o_data stable while stalled, all 6 words delivered in order, none lost or duplicated.
- Counter saturation/clear: CNT_WD=4, send 20 single-error words → o_err_cnt stops at 15; assert i_cnt_clr on a cycle with an errored output handshake → o_err_cnt=0 next cycle.
- Reset mid-operation: 2 words in flight, pulse i_rst → o_valid=0, o_err_cnt=0 next cycle, no stale word emitted afterwards.
- Random: random data, random 0/1-bit errors, random i_valid/i_ready → scoreboard matches reference encode/decode model exactly.

Source files
------------

// File: rtl/hc_dec_pipe.sv
// hc_dec_pipe -- two-stage, flow-controlled Hamming (7,4) decoder.
//
// Takes one 7-bit codeword per cycle. The first stage stores the codeword
// and its syndrome. The second stage stores the corrected data word with its
// error status. A saturating counter tracks how many corrected words have
// been delivered.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      upstream codeword valid
//   o_ready      decoder can take a codeword this cycle
//   i_enc_data   codeword, bit k = Hamming position k+1
//   o_valid      output word valid
//   i_ready      downstream accepts the output word
//   o_data       corrected data {d3,d2,d1,d0}
//   o_err        non-zero syndrome seen, word was corrected
//   o_syndrome   syndrome of the output word (erroneous position, 0 if clean)
//   o_err_cnt    saturating count of corrected words delivered
//   i_cnt_clr    synchronous clear of o_err_cnt (wins over increment)
//
// Only DATA_WD=4 / CHK_WD=3 is meaningful. The bit positions below are fixed
// to the (7,4) layout.
module hc_dec_pipe #(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3,
  parameter int CNT_WD  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_WD+CHK_WD-1:0]  i_enc_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WD-1:0]         o_data,
  output logic                       o_err,
  output logic [CHK_WD-1:0]          o_syndrome,
  output logic [CNT_WD-1:0]          o_err_cnt,
  input  logic                       i_cnt_clr
);

  localparam int CW_WD = DATA_WD + CHK_WD;

  // Stage 1: raw codeword + syndrome
  logic              s1_valid_q, s1_valid_d;
  logic [CW_WD-1:0]  s1_cw_q,    s1_cw_d;
  logic [CHK_WD-1:0] s1_syn_q,   s1_syn_d;

  // Stage 2: corrected result presented on the outputs
  logic               s2_valid_q, s2_valid_d;
  logic [DATA_WD-1:0] s2_data_q,  s2_data_d;
  logic               s2_err_q,   s2_err_d;
  logic [CHK_WD-1:0]  s2_syn_q,   s2_syn_d;

  logic [CNT_WD-1:0]  cnt_q, cnt_d;

  logic              s2_free, in_hs, s1_adv, out_hs;
  logic [CHK_WD-1:0] syn_in;
  logic [CW_WD-1:0]  flip, corr;

  // Handshake / advance terms. o_ready looks only at registered state and
  // i_ready, so it has no path from i_valid.
  assign s2_free = !s2_valid_q || i_ready;
  assign o_ready = !s1_valid_q || s2_free;
  assign in_hs   = i_valid && o_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign out_hs  = s2_valid_q && i_ready;

  // Syndrome bit k covers every position whose 1-based index has bit k set.
  assign syn_in = {i_enc_data[3] ^ i_enc_data[4] ^ i_enc_data[5] ^ i_enc_data[6],
                   i_enc_data[1] ^ i_enc_data[2] ^ i_enc_data[5] ^ i_enc_data[6],
                   i_enc_data[0] ^ i_enc_data[2] ^ i_enc_data[4] ^ i_enc_data[6]};

  // A non-zero syndrome names the 1-based position to invert. Zero matches
  // no position, so clean words pass through unchanged.
  always_comb begin
    flip = '0;
    for (int p = 0; p < CW_WD; p++)
      flip[p] = (s1_syn_q == CHK_WD'(p + 1));
  end

  assign corr = s1_cw_q ^ flip;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_cw_d    = i_enc_data;
      s1_syn_d   = syn_in;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // When S2 is stalled, its contents are left alone, so the outputs hold.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    s2_syn_d   = s2_syn_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = {corr[6], corr[5], corr[4], corr[2]};
      s2_err_d   = |s1_syn_q;
      s2_syn_d   = s1_syn_q;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr)
      cnt_d = '0;
    else if (out_hs && s2_err_q && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_syn_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cw_q    <= s1_cw_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
      s2_syn_q   <= s2_syn_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_data     = s2_data_q;
  assign o_err      = s2_err_q;
  assign o_syndrome = s2_syn_q;
  assign o_err_cnt  = cnt_q;

endmodule
